// File: rtl/ic0_mst_bridge.sv
// CPU load/store to ic0 master strobe bridge, one outstanding transaction, read timeout.
// Optional macro IC0_MST_BRIDGE_ERRCNT_EN adds a saturating error-response counter.
module ic0_mst_bridge #(
   parameter int          NSLV     = 4,
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
   output logic [15:0]          err_count,
`endif
   input  logic                 cpu_req_valid,
   output logic                 cpu_req_ready,
   input  logic                 cpu_req_we,
   input  logic [31:0]          cpu_req_addr,
   input  logic [31:0]          cpu_req_wdata,
   output logic                 cpu_rsp_valid,
   input  logic                 cpu_rsp_ready,
   output logic [31:0]          cpu_rsp_rdata,
   output logic                 cpu_rsp_err,
   output logic                 ic0_c_axi_mst_wr_valid,
   output logic                 ic0_c_axi_mst_rd_valid,
   output logic [31:0]          ic0_axi_mst_wr_addr,
   output logic [31:0]          ic0_axi_mst_wr_data,
   output logic [31:0]          ic0_axi_mst_rd_addr,
   input  logic [NSLV-1:0]      ic0_c_axi_slv_rd_ready,
   input  logic [NSLV*32-1:0]   ic0_axi_slv_rd_data
);

   typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic [31:0] rd_or;
   logic        any_rdy;
   logic        multi_rdy;
   logic        to_hit;
   logic        err_event;

   always_comb begin
      rd_or = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (ic0_c_axi_slv_rd_ready[i]) begin
            rd_or = rd_or | ic0_axi_slv_rd_data[32*i +: 32];
         end
      end
   end

   // More than one bit set: clearing the lowest set bit leaves something behind.
   assign any_rdy   = |ic0_c_axi_slv_rd_ready;
   assign multi_rdy = |(ic0_c_axi_slv_rd_ready & (ic0_c_axi_slv_rd_ready - NSLV'(1)));
   assign cnt_next  = cnt + 8'd1;
   assign to_hit    = (cnt_next == 8'(TIMEOUT));
   assign err_event = (state == WAIT) && (any_rdy ? multi_rdy : to_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= IDLE;
         cnt                    <= '0;
         cpu_req_ready          <= 1'b0;
         cpu_rsp_valid          <= 1'b0;
         cpu_rsp_rdata          <= '0;
         cpu_rsp_err            <= 1'b0;
         ic0_c_axi_mst_wr_valid <= 1'b0;
         ic0_c_axi_mst_rd_valid <= 1'b0;
         ic0_axi_mst_wr_addr    <= '0;
         ic0_axi_mst_wr_data    <= '0;
         ic0_axi_mst_rd_addr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cpu_req_ready <= 1'b1;
               if (cpu_req_valid && cpu_req_ready) begin
                  cpu_req_ready <= 1'b0;
                  if (cpu_req_we) begin
                     ic0_axi_mst_wr_addr    <= cpu_req_addr;
                     ic0_axi_mst_wr_data    <= cpu_req_wdata;
                     ic0_c_axi_mst_wr_valid <= 1'b1;
                     state                  <= WR;
                  end else begin
                     ic0_axi_mst_rd_addr    <= cpu_req_addr;
                     ic0_c_axi_mst_rd_valid <= 1'b1;
                     state                  <= RD;
                  end
               end
            end
            WR: begin
               ic0_c_axi_mst_wr_valid <= 1'b0;
               cpu_rsp_valid          <= 1'b1;
               cpu_rsp_rdata          <= '0;
               cpu_rsp_err            <= 1'b0;
               state                  <= RSP;
            end
            RD: begin
               ic0_c_axi_mst_rd_valid <= 1'b0;
               cnt                    <= '0;
               state                  <= WAIT;
            end
            WAIT: begin
               cnt <= cnt_next;
               // A ready arriving on the timeout cycle still wins.
               if (any_rdy) begin
                  cpu_rsp_valid <= 1'b1;
                  cpu_rsp_rdata <= rd_or;
                  cpu_rsp_err   <= multi_rdy;
                  state         <= RSP;
               end else if (to_hit) begin
                  cpu_rsp_valid <= 1'b1;
                  cpu_rsp_rdata <= ERR_DATA;
                  cpu_rsp_err   <= 1'b1;
                  state         <= RSP;
               end
            end
            RSP: begin
               if (cpu_rsp_ready) begin
                  cpu_rsp_valid <= 1'b0;
                  cpu_req_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IC0_MST_BRIDGE_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_event && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ic0_mst_bridge.sv
// Randomized self-checking bench for ic0_mst_bridge against a transaction-level reference model.
module tb_ic0_mst_bridge;

   localparam int          NSLV     = 4;
   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] ERR_DATA = 32'h0000_0000;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [31:0]         cpu_req_addr, cpu_req_wdata;
   logic                cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
   logic [31:0]         cpu_rsp_rdata;
   logic                wr_valid, rd_valid;
   logic [31:0]         wr_addr, wr_data, rd_addr;
   logic [NSLV-1:0]     slv_ready;
   logic [NSLV*32-1:0]  slv_data;
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
   logic [15:0]         err_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int exp_errs = 0;

   // Last observed transaction
   int          obs_k, obs_wr_cnt, obs_rd_cnt;
   logic [31:0] obs_rdata, obs_wr_addr, obs_wr_data, obs_rd_addr;
   logic        obs_err;
   bit          obs_to, obs_unstable, obs_after_bad;
   logic [31:0] sdat [NSLV];

   ic0_mst_bridge #(.NSLV(NSLV), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
      .err_count(err_count),
`endif
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
      .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
      .ic0_c_axi_mst_wr_valid(wr_valid), .ic0_c_axi_mst_rd_valid(rd_valid),
      .ic0_axi_mst_wr_addr(wr_addr), .ic0_axi_mst_wr_data(wr_data),
      .ic0_axi_mst_rd_addr(rd_addr),
      .ic0_c_axi_slv_rd_ready(slv_ready), .ic0_axi_slv_rd_data(slv_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: cycle after accept at which rsp_valid is first seen, and response contents.
   function automatic bit read_hits(input int lat, input logic [NSLV-1:0] mask);
      return (mask != '0) && (lat >= 1) && (lat <= TIMEOUT);
   endfunction

   function automatic int exp_rsp_k(input bit we, input int lat, input logic [NSLV-1:0] mask);
      if (we) return 2;
      return read_hits(lat, mask) ? 2 + lat : 2 + TIMEOUT;
   endfunction

   function automatic logic [31:0] exp_rdata(input bit we, input int lat, input logic [NSLV-1:0] mask);
      logic [31:0] r = '0;
      if (we) return 32'h0;
      if (!read_hits(lat, mask)) return ERR_DATA;
      for (int i = 0; i < NSLV; i++) if (mask[i]) r |= sdat[i];
      return r;
   endfunction

   function automatic logic exp_err(input bit we, input int lat, input logic [NSLV-1:0] mask);
      if (we) return 1'b0;
      if (!read_hits(lat, mask)) return 1'b1;
      return $countones(mask) > 1;
   endfunction

   // Drives one request, plays the slaves, holds off the response for 'hold' cycles, then consumes it.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [NSLV-1:0] mask, input int hold, input bit spurious);
      int strobe_k = -1;
      int w = 0;
      obs_k = -1; obs_wr_cnt = 0; obs_rd_cnt = 0; obs_rdata = '0; obs_err = 1'b0;
      obs_to = 0; obs_unstable = 0; obs_after_bad = 0;
      obs_wr_addr = 'x; obs_wr_data = 'x; obs_rd_addr = 'x;
      while (cpu_req_ready !== 1'b1 && w < 20) begin step(); w++; end
      if (cpu_req_ready !== 1'b1) begin obs_to = 1; return; end
      cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
      step();
      cpu_req_valid = 1'b0; cpu_req_addr = $urandom; cpu_req_wdata = $urandom;
      for (int k = 1; k <= 60; k++) begin
         if (wr_valid === 1'b1) begin obs_wr_cnt++; obs_wr_addr = wr_addr; obs_wr_data = wr_data; end
         if (rd_valid === 1'b1) begin obs_rd_cnt++; obs_rd_addr = rd_addr; strobe_k = k; end
         if (cpu_rsp_valid === 1'b1) begin
            obs_k = k; obs_rdata = cpu_rsp_rdata; obs_err = cpu_rsp_err;
            break;
         end
         slv_ready = '0; slv_data = '0;
         if (spurious && k == strobe_k) begin slv_ready = '1; slv_data = '1; end
         if (strobe_k >= 0 && k == strobe_k + lat) begin
            slv_ready = mask;
            for (int i = 0; i < NSLV; i++) if (mask[i]) slv_data[32*i +: 32] = sdat[i];
         end
         step();
      end
      slv_ready = '0; slv_data = '0;
      if (obs_k < 0) begin obs_to = 1; return; end
      for (int h = 0; h < hold; h++) begin
         step();
         if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== obs_rdata || cpu_rsp_err !== obs_err ||
             cpu_req_ready !== 1'b0 || wr_valid !== 1'b0 || rd_valid !== 1'b0) obs_unstable = 1;
      end
      if (cpu_req_ready !== 1'b0) obs_unstable = 1;
      cpu_rsp_ready = 1'b1;
      step();
      cpu_rsp_ready = 1'b0;
      if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1) obs_after_bad = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, wr_valid, rd_valid} !== 5'b0 ||
          cpu_rsp_rdata !== 32'h0 || wr_addr !== 32'h0 || wr_data !== 32'h0 || rd_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: ready=%b rsp_valid=%b rdata=%h wr_addr=%h rd_addr=%h, required all 0",
                  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, wr_addr, rd_addr);
      end
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
      n_cmp++;
      if (err_count !== 16'h0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", cpu_req_ready); end
   endtask

   task automatic test_write();
      run_txn(1'b1, 32'h454, 32'h5, 0, '0, 0, 1'b0);
      n_cmp++;
      if (obs_to || obs_k != 2) begin n_bad++; $display("FAIL write_latency: got %0d want 2 (to=%0b)", obs_k, obs_to); end
      n_cmp++;
      if (obs_wr_cnt != 1 || obs_rd_cnt != 0) begin
         n_bad++; $display("FAIL write_strobes: wr=%0d rd=%0d want wr=1 rd=0", obs_wr_cnt, obs_rd_cnt);
      end
      n_cmp++;
      if (obs_wr_addr !== 32'h454 || obs_wr_data !== 32'h5) begin
         n_bad++; $display("FAIL write_addr_data: got %h/%h want 454/5", obs_wr_addr, obs_wr_data);
      end
      n_cmp++;
      if (obs_err !== 1'b0 || obs_rdata !== 32'h0 || obs_after_bad) begin
         n_bad++; $display("FAIL write_rsp: err=%b rdata=%h after_bad=%0b want 0/0/0", obs_err, obs_rdata, obs_after_bad);
      end
      n_cmp++;
      if (rd_addr !== 32'h0) begin n_bad++; $display("FAIL write_rd_addr_hold: got %h want 0", rd_addr); end
   endtask

   task automatic test_read();
      sdat[0] = 32'h0000_000A;
      run_txn(1'b0, 32'h460, 32'h0, 1, 4'b0001, 0, 1'b0);
      n_cmp++;
      if (obs_k != 3) begin n_bad++; $display("FAIL read_latency: got %0d want 3", obs_k); end
      n_cmp++;
      if (obs_rdata !== 32'hA || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL read_rsp: rdata=%h err=%b want 0000000a/0", obs_rdata, obs_err);
      end
      n_cmp++;
      if (obs_rd_cnt != 1 || obs_wr_cnt != 0 || obs_rd_addr !== 32'h460) begin
         n_bad++; $display("FAIL read_strobe: rd=%0d wr=%0d addr=%h want 1/0/460", obs_rd_cnt, obs_wr_cnt, obs_rd_addr);
      end
      n_cmp++;
      if (wr_addr !== 32'h454 || wr_data !== 32'h5) begin
         n_bad++; $display("FAIL read_wr_hold: got %h/%h want 454/5", wr_addr, wr_data);
      end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 32'h470, 32'h0, 0, '0, 0, 1'b0);
      exp_errs++;
      n_cmp++;
      if (obs_k != 2 + TIMEOUT) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", obs_k, 2 + TIMEOUT); end
      n_cmp++;
      if (obs_rdata !== ERR_DATA || obs_err !== 1'b1) begin
         n_bad++; $display("FAIL timeout_rsp: rdata=%h err=%b want %h/1", obs_rdata, obs_err, ERR_DATA);
      end
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
      n_cmp++;
      if (err_count !== 16'(exp_errs)) begin n_bad++; $display("FAIL timeout_err_count: got %0d want %0d", err_count, exp_errs); end
`endif
   endtask

   task automatic test_multi();
      sdat[1] = 32'h0F00; sdat[2] = 32'h00F0;
      run_txn(1'b0, 32'h480, 32'h0, 2, 4'b0110, 0, 1'b0);
      exp_errs++;
      n_cmp++;
      if (obs_rdata !== 32'h0FF0 || obs_err !== 1'b1 || obs_k != 4) begin
         n_bad++; $display("FAIL multi_slave: rdata=%h err=%b k=%0d want 00000ff0/1/4", obs_rdata, obs_err, obs_k);
      end
   endtask

   task automatic test_boundary();
      sdat[3] = 32'hCAFE_0003;
      run_txn(1'b0, 32'h490, 32'h0, TIMEOUT, 4'b1000, 0, 1'b0);
      n_cmp++;
      if (obs_k != 2 + TIMEOUT || obs_rdata !== 32'hCAFE_0003 || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL ready_at_timeout: k=%0d rdata=%h err=%b want %0d/cafe0003/0",
                           obs_k, obs_rdata, obs_err, 2 + TIMEOUT);
      end
   endtask

   task automatic test_backpressure();
      sdat[2] = 32'h1234_5678;
      run_txn(1'b0, 32'h4A0, 32'h0, 3, 4'b0100, 10, 1'b1);
      n_cmp++;
      if (obs_unstable || obs_after_bad) begin
         n_bad++; $display("FAIL backpressure: unstable=%0b after_bad=%0b want 0/0", obs_unstable, obs_after_bad);
      end
      n_cmp++;
      if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL backpressure_rsp: rdata=%h err=%b want 12345678/0", obs_rdata, obs_err);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h4B0;
      step();
      cpu_req_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cpu_req_ready, cpu_rsp_valid, rd_valid, wr_valid} !== 4'b0 || rd_addr !== 32'h0 || wr_addr !== 32'h0) begin
         n_bad++; $display("FAIL mid_reset_outputs: ready=%b rsp_valid=%b rd_addr=%h want 0", cpu_req_ready, cpu_rsp_valid, rd_addr);
      end
      exp_errs = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      slv_ready = 4'b0001; slv_data = '0; slv_data[31:0] = 32'h55;
      step();
      slv_ready = '0; slv_data = '0;
      for (int i = 0; i < 6; i++) begin
         if (cpu_rsp_valid !== 1'b0 || rd_valid !== 1'b0) seen = 1;
         step();
      end
      n_cmp++;
      if (seen || cpu_req_ready !== 1'b1) begin
         n_bad++; $display("FAIL mid_reset_stale: stale_rsp=%0b ready=%b want 0/1", seen, cpu_req_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0] last_wa = wr_addr, last_wd = wr_data, last_ra = rd_addr;
      for (int t = 0; t < 40; t++) begin
         bit          we = $urandom_range(0, 2) == 0;
         logic [31:0] a = $urandom, d = $urandom;
         int          lat = $urandom_range(1, TIMEOUT + 3);
         logic [NSLV-1:0] m = NSLV'($urandom_range(0, 15));
         int          hold = $urandom_range(0, 3);
         for (int i = 0; i < NSLV; i++) sdat[i] = $urandom;
         run_txn(we, a, d, lat, m, hold, $urandom_range(0, 1) == 1);
         if (we) begin last_wa = a; last_wd = d; end else last_ra = a;
         if (exp_err(we, lat, m)) exp_errs++;
         n_cmp++;
         if (obs_to || obs_k != exp_rsp_k(we, lat, m)) begin
            n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, obs_k, exp_rsp_k(we, lat, m));
         end
         n_cmp++;
         if (obs_rdata !== exp_rdata(we, lat, m) || obs_err !== exp_err(we, lat, m)) begin
            n_bad++; $display("FAIL rand_rsp[%0d]: rdata=%h err=%b want %h/%b", t, obs_rdata, obs_err,
                              exp_rdata(we, lat, m), exp_err(we, lat, m));
         end
         n_cmp++;
         if (obs_wr_cnt != (we ? 1 : 0) || obs_rd_cnt != (we ? 0 : 1) || obs_unstable || obs_after_bad) begin
            n_bad++; $display("FAIL rand_strobes[%0d]: wr=%0d rd=%0d unstable=%0b after=%0b", t,
                              obs_wr_cnt, obs_rd_cnt, obs_unstable, obs_after_bad);
         end
         n_cmp++;
         if (wr_addr !== last_wa || wr_data !== last_wd || rd_addr !== last_ra) begin
            n_bad++; $display("FAIL rand_addr_hold[%0d]: got %h/%h/%h want %h/%h/%h", t,
                              wr_addr, wr_data, rd_addr, last_wa, last_wd, last_ra);
         end
      end
`ifdef IC0_MST_BRIDGE_ERRCNT_EN
      n_cmp++;
      if (err_count !== 16'(exp_errs)) begin n_bad++; $display("FAIL rand_err_count: got %0d want %0d", err_count, exp_errs); end
`endif
   endtask

   initial begin
      cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
      cpu_rsp_ready = 1'b0; slv_ready = '0; slv_data = '0;
      for (int i = 0; i < NSLV; i++) sdat[i] = '0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_multi();
      test_boundary();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
